seven_seg_driver: RTL and testbench

Four-digit multiplexed seven-segment display driver with 8-bit PWM brightness control. It takes four BCD digits (HH:MM from the clock core) and a brightness word from the slide switches. It time-multiplexes the common-anode digit enables and drives active-low segment lines on the board's display. It sits between the 24-hour clock counter and the top-level display pins, and uses the delayed/synchronised reset.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seven_seg_driver_if.sv | 20 ++
 rtl/seven_seg_driver_bcd_to_seg.sv | 26 ++
 rtl/seven_seg_driver.sv | 75 +++++++
 tb/tb_seven_seg_driver.sv | 137 +++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment patterns and digit index type for seven_seg_driver
package seven_seg_pkg;

  typedef logic [1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}; dp is merged separately by the top level
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam digit_idx_t DP_DIGIT = 2'd2;

  localparam logic [3:0] DRV_ALL_OFF = 4'hF;
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

endpackage

// File: rtl/seven_seg_driver_if.sv
// rtl/seven_seg_driver_if.sv - digit/brightness inputs and display pin outputs of seven_seg_driver
interface seven_seg_driver_if;
  logic [3:0] BCD3;
  logic [3:0] BCD2;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic [7:0] PWM;
  logic [3:0] SegmentDrivers;
  logic [7:0] SevenSegment;

  modport master (
    output BCD3, BCD2, BCD1, BCD0, PWM,
    input  SegmentDrivers, SevenSegment
  );

  modport slave (
    input  BCD3, BCD2, BCD1, BCD0, PWM,
    output SegmentDrivers, SevenSegment
  );
endinterface

// File: rtl/seven_seg_driver_bcd_to_seg.sv
// rtl/seven_seg_driver_bcd_to_seg.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_driver.sv
// rtl/seven_seg_driver.sv - 4-digit multiplexed 7-segment driver with PWM dimming; SEVEN_SEG_LZ_BLANK_EN blanks a leading zero
module seven_seg_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_SEL_LSB = 18
) (
  input  logic               Clk_100M,
  input  logic               Reset,
  seven_seg_driver_if.slave  disp
);

  localparam int CW = DIGIT_SEL_LSB + 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    drv_q, drv_d;
  logic [7:0]    seg_q, seg_d;

  digit_idx_t    sel;
  logic          lit;
  logic [3:0]    bcd_sel;
  logic [6:0]    seg_raw;
  logic [6:0]    seg7;
  logic          dp_n;

  always_comb begin
    sel = cnt_q[DIGIT_SEL_LSB+1:DIGIT_SEL_LSB];
    lit = (cnt_q[7:0] < disp.PWM);
    case (sel)
      2'd0:    bcd_sel = disp.BCD0;
      2'd1:    bcd_sel = disp.BCD1;
      2'd2:    bcd_sel = disp.BCD2;
      default: bcd_sel = disp.BCD3;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd_i (bcd_sel),
    .seg_o (seg_raw)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Leading hours zero is suppressed but its enable stays asserted
  assign seg7 = ((sel == 2'd3) && (disp.BCD3 == 4'd0)) ? SEG_BLANK : seg_raw;
`else
  assign seg7 = seg_raw;
`endif

  assign dp_n = (sel != DP_DIGIT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    drv_d = DRV_ALL_OFF;
    seg_d = SEG_ALL_OFF;
    if (lit) begin
      drv_d = ~(4'b0001 << sel);
      seg_d = {dp_n, seg7};
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      cnt_q <= '0;
      drv_q <= DRV_ALL_OFF;
      seg_q <= SEG_ALL_OFF;
    end else begin
      cnt_q <= cnt_d;
      drv_q <= drv_d;
      seg_q <= seg_d;
    end
  end

  assign disp.SegmentDrivers = drv_q;
  assign disp.SevenSegment   = seg_q;

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb/tb_seven_seg_driver.sv - scoreboard testbench for seven_seg_driver with DIGIT_SEL_LSB = 8
module tb_seven_seg_driver;

  typedef struct packed {
    logic       rst;
    logic [9:0] src;
    logic [7:0] pwm;
    logic [3:0] drv;
    logic [7:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  seven_seg_driver_if bus ();

  seven_seg_driver #(.DIGIT_SEL_LSB(8)) dut (
    .Clk_100M (clk),
    .Reset    (Reset),
    .disp     (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] b3 = 4'd1, b2 = 4'd2, b1 = 4'd3, b0 = 4'd4;
  logic [7:0] pwm = 8'd255;
  logic [9:0] model_cnt = '0;

  function automatic logic [6:0] exp_seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;
      4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic step(input logic rst);
    exp_t       e;
    logic [1:0] s;
    logic [3:0] d;
    logic [6:0] s7;
    @(negedge clk);
    Reset = rst;
    bus.BCD3 = b3; bus.BCD2 = b2; bus.BCD1 = b1; bus.BCD0 = b0; bus.PWM = pwm;
    e.rst = rst; e.src = model_cnt; e.pwm = pwm;
    e.drv = 4'hF; e.seg = 8'hFF;
    s = model_cnt[9:8];
    if (!rst && (model_cnt[7:0] < pwm)) begin
      case (s)
        2'd0: begin e.drv = 4'hE; d = b0; end
        2'd1: begin e.drv = 4'hD; d = b1; end
        2'd2: begin e.drv = 4'hB; d = b2; end
        default: begin e.drv = 4'h7; d = b3; end
      endcase
      s7 = exp_seg7(d);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (s == 2'd3 && b3 == 4'd0) s7 = 7'h7F;
`endif
      e.seg = {(s != 2'd2), s7};
    end
    sb_q.push_back(e);
    model_cnt = rst ? 10'd0 : model_cnt + 10'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Monitor: pops one expectation per output update; also counts lit cycles per PWM window
  int         win_lit   = 0;
  logic       win_valid = 1'b0;
  logic [7:0] win_pwm   = '0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.SegmentDrivers !== e.drv) begin
        n_fail++;
        $display("FAIL drv src=%0d actual=%h required=%h", e.src, bus.SegmentDrivers, e.drv);
      end
      n_checks++;
      if (bus.SevenSegment !== e.seg) begin
        n_fail++;
        $display("FAIL seg src=%0d actual=%h required=%h", e.src, bus.SevenSegment, e.seg);
      end
      if (e.rst) begin
        win_valid = 1'b0;
      end else begin
        if (e.src[7:0] == 8'd0) begin
          win_valid = 1'b1; win_pwm = e.pwm; win_lit = 0;
        end else if (e.pwm != win_pwm) begin
          win_valid = 1'b0;
        end
        if (bus.SegmentDrivers != 4'hF) win_lit++;
        if (e.src[7:0] == 8'd255 && win_valid) begin
          n_checks++;
          if (win_lit != int'(win_pwm)) begin
            n_fail++;
            $display("FAIL pwm_window pwm=%0d actual_lit=%0d required_lit=%0d", win_pwm, win_lit, win_pwm);
          end
        end
      end
    end
  end

  initial begin
    bus.BCD3 = b3; bus.BCD2 = b2; bus.BCD1 = b1; bus.BCD0 = b0; bus.PWM = pwm;
    // Reset held 3 cycles, then 1,2,3,4 at full brightness for over one frame
    step(1'b1); step(1'b1); step(1'b1);
    run(1100);
    pwm = 8'd0;   run(1024);
    pwm = 8'd64;  run(1280);
    pwm = 8'd255; b0 = 4'd12; run(1024);
    b3 = 4'd0; b2 = 4'd9; b1 = 4'd0; b0 = 4'd5; run(1024);
    // Mid-frame reset restarts at digit 0, phase 0
    run(300); step(1'b1); run(600);
    pwm = 8'd128; run(100); pwm = 8'd200; run(700);
    b3 = 4'd15; b2 = 4'd10; b1 = 4'd7; b0 = 4'd8; pwm = 8'd1; run(1024);
    @(posedge clk); #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
